cpu_bus_io: RTL and testbench

CPU_BUS_IO -- requirements
Module: cpu_bus_io

---
 rtl/cpu_bus_io.sv | 177 +++++++++++++++++
 tb/tb_cpu_bus_io.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_io.sv
// CPU bus splitter. The I/O page (adder[7:4] == IO_PAGE) is decoded into a
// small register file that holds a TX byte FIFO, an RX holding register, GPIO
// and a reloading down-counter timer. All other addresses pass straight
// through to external memory.
module cpu_bus_io #(
  parameter int          TX_DEPTH = 4,
  parameter logic [3:0]  IO_PAGE  = 4'hF
) (
  input  logic       m_clock,
  input  logic       p_reset,
  input  logic [7:0] adder,
  input  logic [7:0] dbuso,
  input  logic       mread,
  input  logic       mwrite,
  output logic [7:0] dbusi,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_re,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out,
  output logic       tmr_tick
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    fifo_q [TX_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_full_q, rx_full_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic [7:0]    gpio_out_q, gpio_out_d;
  logic [7:0]    sync1_q, sync2_q;
  logic [7:0]    reload_q, reload_d, cnt_q, cnt_d;
  logic          en_q, en_d, flag_q, flag_d;

  logic          io_sel, io_wr, io_rd;
  logic [3:0]    off;
  logic          tx_full, tx_empty, pop, push, wr_tx;
  logic [7:0]    status, rd_mux;

  assign io_sel   = (adder[7:4] == IO_PAGE);
  assign off      = adder[3:0];
  assign io_wr    = io_sel & mwrite;
  assign io_rd    = io_sel & mread;

  assign mem_addr  = adder;
  assign mem_wdata = dbuso;
  assign mem_re    = mread & ~io_sel;
  assign mem_we    = mwrite & ~io_sel;

  assign tx_full  = (count_q == CW'(TX_DEPTH));
  assign tx_empty = (count_q == '0);
  assign tx_valid = ~tx_empty;
  assign tx_data  = fifo_q[rd_ptr_q];
  assign pop      = tx_valid & tx_ready;
  assign wr_tx    = io_wr & (off == 4'h0);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push     = wr_tx & (~tx_full | pop);

  assign rx_ready = ~rx_full_q;
  assign gpio_out = gpio_out_q;
  assign tmr_tick = en_q & (cnt_q == 8'h00);
  assign status   = {3'b000, tx_ovf_q, flag_q, rx_full_q, tx_empty, tx_full};

  // Read path: register mux for the I/O page, memory data otherwise, 0 when idle.
  always_comb begin
    rd_mux = 8'h00;
    case (off)
      4'h1:    rd_mux = status;
      4'h2:    rd_mux = rx_byte_q;
      4'h4:    rd_mux = gpio_out_q;
      4'h5:    rd_mux = sync2_q;
      4'h8:    rd_mux = reload_q;
      4'h9:    rd_mux = cnt_q;
      4'hA:    rd_mux = {6'b000000, flag_q, en_q};
      default: rd_mux = 8'h00;
    endcase
    if (!mread)      dbusi = 8'h00;
    else if (io_sel) dbusi = rd_mux;
    else             dbusi = mem_rdata;
  end

  // Next-state for FIFO pointers, status flags, RX, GPIO and timer.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tx_ovf_d   = tx_ovf_q;
    rx_full_d  = rx_full_q;
    rx_byte_d  = rx_byte_q;
    gpio_out_d = gpio_out_q;
    reload_d   = reload_q;
    cnt_d      = cnt_q;
    en_d       = en_q;
    flag_d     = flag_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    // Overflow set takes priority over a software clear in the same cycle.
    if (io_wr && off == 4'h1 && dbuso[4]) tx_ovf_d = 1'b0;
    if (wr_tx && tx_full && !pop)         tx_ovf_d = 1'b1;

    if (io_rd && off == 4'h2 && rx_full_q) begin
      rx_full_d = 1'b0;
    end else if (rx_valid && !rx_full_q) begin
      rx_full_d = 1'b1;
      rx_byte_d = rx_data;
    end

    if (io_wr && off == 4'h4) gpio_out_d = dbuso;

    if (tmr_tick)                               flag_d = 1'b1;
    else if (io_wr && off == 4'hA && dbuso[1])  flag_d = 1'b0;

    // A software reload beats the automatic reload on expiry.
    if (io_wr && off == 4'h8) begin
      reload_d = dbuso;
      cnt_d    = dbuso;
    end else if (en_q) begin
      cnt_d = (cnt_q == 8'h00) ? reload_q : cnt_q - 8'd1;
    end

    if (io_wr && off == 4'hA) en_d = dbuso[0];
  end

  // FIFO storage; contents are don't-care while the FIFO is empty, so no reset.
  always_ff @(posedge m_clock) begin
    if (push) fifo_q[wr_ptr_q] <= dbuso;
  end

  // Control and status registers with asynchronous reset.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_ovf_q   <= 1'b0;
      rx_full_q  <= 1'b0;
      rx_byte_q  <= 8'h00;
      gpio_out_q <= 8'h00;
      sync1_q    <= 8'h00;
      sync2_q    <= 8'h00;
      reload_q   <= 8'h00;
      cnt_q      <= 8'h00;
      en_q       <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_full_q  <= rx_full_d;
      rx_byte_q  <= rx_byte_d;
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      reload_q   <= reload_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      flag_q     <= flag_d;
    end
  end

endmodule

// File: tb/tb_cpu_bus_io.sv
// Scoreboarded bench for cpu_bus_io with a queue-based reference model.
module tb_cpu_bus_io;

  logic       m_clock = 1'b0;
  logic       p_reset = 1'b1;
  logic [7:0] adder = 8'h00, dbuso = 8'h00;
  logic       mread = 1'b0, mwrite = 1'b0;
  logic [7:0] dbusi, mem_addr, mem_wdata;
  logic       mem_re, mem_we;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] gpio_in = 8'h00;
  logic [7:0] gpio_out;
  logic       tmr_tick;

  cpu_bus_io dut (
    .m_clock(m_clock), .p_reset(p_reset), .adder(adder), .dbuso(dbuso),
    .mread(mread), .mwrite(mwrite), .dbusi(dbusi), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .tmr_tick(tmr_tick)
  );

  always #5 m_clock = ~m_clock;

  int checks = 0, failures = 0, tick_cnt = 0;
  logic       run = 1'b0;
  logic       ovr_en = 1'b0;
  logic [7:0] ovr_val = 8'h00;
  logic [7:0] tx_m[$], tx_exp[$], rd_exp[$];

  // reference model state
  logic       ovf_m, rx_full_m, en_m, flag_m;
  logic [7:0] rx_byte_m, gpio_out_m, s1_m, s2_m, reload_m, count_m;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h required=%02h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    tx_m.delete(); tx_exp.delete(); rd_exp.delete();
    ovf_m = 0; rx_full_m = 0; en_m = 0; flag_m = 0;
    rx_byte_m = 0; gpio_out_m = 0; s1_m = 0; s2_m = 0; reload_m = 0; count_m = 0;
  endtask

  function automatic logic [7:0] model_rd(input logic [3:0] off);
    case (off)
      4'h1: return {3'b000, ovf_m, flag_m, rx_full_m, tx_m.size() == 0, tx_m.size() == 4};
      4'h2: return rx_byte_m;
      4'h4: return gpio_out_m;
      4'h5: return s2_m;
      4'h8: return reload_m;
      4'h9: return count_m;
      4'hA: return {6'b000000, flag_m, en_m};
      default: return 8'h00;
    endcase
  endfunction

  // One bus cycle: predict, check combinational outputs, clock, advance model.
  task automatic step();
    logic io, pop, full, wtx, wr;
    logic [3:0] off;
    logic [7:0] e;
    io  = (adder[7:4] == 4'hF);
    off = adder[3:0];
    wr  = io && mwrite;
    if (mread) begin
      e = io ? model_rd(off) : mem_rdata;
      if (ovr_en) e = ovr_val;
      rd_exp.push_back(e);
    end
    ovr_en = 1'b0;
    #1;
    chk("flags", {3'b000, tx_valid, rx_ready, tmr_tick, mem_re, mem_we},
        {3'b000, tx_m.size() != 0, !rx_full_m, en_m && count_m == 0, mread && !io, mwrite && !io});
    chk("gpio_out", gpio_out, gpio_out_m);
    if (!io) begin
      chk("mem_addr", mem_addr, adder);
      chk("mem_wdata", mem_wdata, dbuso);
    end
    if (tmr_tick) tick_cnt++;
    @(posedge m_clock);
    pop  = (tx_m.size() != 0) && tx_ready;
    full = (tx_m.size() == 4);
    wtx  = wr && off == 4'h0;
    if (pop) void'(tx_m.pop_front());
    if (wtx && (!full || pop)) begin
      tx_m.push_back(dbuso);
      tx_exp.push_back(dbuso);
    end
    if (wr && off == 4'h1 && dbuso[4]) ovf_m = 0;
    if (wtx && full && !pop) ovf_m = 1;
    if (io && mread && off == 4'h2 && rx_full_m) rx_full_m = 0;
    else if (rx_valid && !rx_full_m) begin
      rx_full_m = 1;
      rx_byte_m = rx_data;
    end
    s2_m = s1_m;
    s1_m = gpio_in;
    if (wr && off == 4'h4) gpio_out_m = dbuso;
    if (en_m && count_m == 0) flag_m = 1;
    else if (wr && off == 4'hA && dbuso[1]) flag_m = 0;
    if (wr && off == 4'h8) begin
      reload_m = dbuso;
      count_m  = dbuso;
    end else if (en_m) begin
      count_m = (count_m == 0) ? reload_m : count_m - 8'd1;
    end
    if (wr && off == 4'hA) en_m = dbuso[0];
    #1;
  endtask

  task automatic bus(input logic [7:0] a, input logic [7:0] d, input logic r, input logic w);
    adder = a; dbuso = d; mread = r; mwrite = w;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic rd_expect(input logic [7:0] a, input logic [7:0] v);
    ovr_en = 1'b1; ovr_val = v;
    bus(a, 8'h00, 1'b1, 1'b0);
  endtask

  // Monitor: pops scoreboard entries whenever the DUT presents read data or a TX byte.
  always @(negedge m_clock) begin
    if (run && !p_reset) begin
      if (mread) begin
        if (rd_exp.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_queue actual=%02h required=none", dbusi);
        end else chk("dbusi", dbusi, rd_exp.pop_front());
      end else chk("dbusi_idle", dbusi, 8'h00);
      if (tx_valid && tx_ready) begin
        if (tx_exp.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_unexpected actual=%02h required=none", tx_data);
        end else chk("tx_data", tx_data, tx_exp.pop_front());
      end
    end
  end

  logic [7:0] addrs [10] = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF8, 8'hF9, 8'hFA, 8'hFE};

  initial begin
    model_reset();
    repeat (2) @(posedge m_clock);
    #1;
    adder = 8'hF1; mread = 1'b1;
    #1;
    chk("rst_status", dbusi, 8'h02);
    chk("rst_outs", {4'b0, tx_valid, rx_ready, tmr_tick, 1'b0}, 8'h04);
    chk("rst_gpio", gpio_out, 8'h00);
    adder = 8'h40; mem_rdata = 8'h77;
    #1;
    chk("rst_passthru", dbusi, 8'h77);
    mread = 1'b0; adder = 8'h00;
    @(posedge m_clock); #1;
    p_reset = 1'b0;
    run = 1'b1;

    // TX FIFO fill, overflow, drain, overflow clear
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) bus(8'hF0, 8'(i * 8'h11), 1'b0, 1'b1);
    rd_expect(8'hF1, 8'h11);
    tx_ready = 1'b1;
    idle(5);
    rd_expect(8'hF1, 8'h12);
    bus(8'hF1, 8'h10, 1'b0, 1'b1);
    rd_expect(8'hF1, 8'h02);

    // push into full FIFO while popping
    tx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) bus(8'hF0, 8'hA0 + 8'(i), 1'b0, 1'b1);
    tx_ready = 1'b1;
    bus(8'hF0, 8'h66, 1'b0, 1'b1);
    tx_ready = 1'b0;
    rd_expect(8'hF1, 8'h01);
    tx_ready = 1'b1;
    idle(6);
    rd_expect(8'hF1, 8'h02);

    // RX capture and read
    rx_valid = 1'b1; rx_data = 8'hA5;
    idle(1);
    rx_valid = 1'b0;
    idle(1);
    rd_expect(8'hF2, 8'hA5);
    idle(1);

    // timer
    bus(8'hF8, 8'h03, 1'b0, 1'b1);
    bus(8'hFA, 8'h01, 1'b0, 1'b1);
    tick_cnt = 0;
    idle(12);
    chk("tick_count", 8'(tick_cnt), 8'd3);
    rd_expect(8'hF1, 8'h0A);
    rd_expect(8'hFA, 8'h03);
    bus(8'hFA, 8'h03, 1'b0, 1'b1);
    bus(8'hFA, 8'h00, 1'b1, 1'b0);
    tick_cnt = 0;
    idle(8);
    chk("tick_continue", 8'(tick_cnt), 8'd2);

    // memory pass-through and GPIO synchronizer
    mem_rdata = 8'h9C;
    rd_expect(8'h40, 8'h9C);
    bus(8'h40, 8'h5D, 1'b0, 1'b1);
    gpio_in = 8'h00;
    idle(3);
    gpio_in = 8'hC3;
    idle(1);
    rd_expect(8'hF5, 8'h00);
    rd_expect(8'hF5, 8'hC3);

    // asynchronous reset with FIFO occupied and timer running
    tx_ready = 1'b0;
    bus(8'hF4, 8'h5A, 1'b0, 1'b1);
    bus(8'hF0, 8'h01, 1'b0, 1'b1);
    bus(8'hF0, 8'h02, 1'b0, 1'b1);
    bus(8'hF8, 8'h03, 1'b0, 1'b1);
    bus(8'hFA, 8'h01, 1'b0, 1'b1);
    idle(2);
    #1;
    p_reset = 1'b1; adder = 8'hF1; mread = 1'b1;
    #1;
    chk("arst_outs", {4'b0, tx_valid, rx_ready, tmr_tick, 1'b0}, 8'h04);
    chk("arst_gpio", gpio_out, 8'h00);
    chk("arst_status", dbusi, 8'h02);
    model_reset();
    @(posedge m_clock); #1;
    mread = 1'b0; adder = 8'h00;
    p_reset = 1'b0;

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [7:0] a;
      int pick;
      tx_ready  = 1'($urandom_range(0, 1));
      rx_valid  = 1'($urandom_range(0, 1));
      rx_data   = 8'($urandom);
      mem_rdata = 8'($urandom);
      if ($urandom_range(0, 7) == 0) gpio_in = 8'($urandom);
      pick = $urandom_range(0, 11);
      a = (pick < 10) ? addrs[pick] : 8'($urandom_range(0, 239));
      bus(a, 8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end
    tx_ready = 1'b1;
    idle(8);
    chk("tx_drain", 8'(tx_exp.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
